// File: rtl/sc_pkg.sv
// Shared types and default sizes for the successive-cancellation decode sequencer.
package sc_pkg;

    localparam int SC_N_LOG   = 10;
    localparam int SC_IDX_W   = 10;
    localparam int SC_LAYER_W = 4;

    typedef enum logic [1:0] {
        SC_F   = 2'd0,
        SC_G   = 2'd1,
        SC_DEC = 2'd2,
        SC_PSU = 2'd3
    } sc_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LLR  = 3'd1,
        ST_DEC  = 3'd2,
        ST_PSU  = 3'd3,
        ST_FIN  = 3'd4
    } sc_state_e;

endpackage

// File: rtl/sc_ctz_layer.sv
// Trailing-zero count plus one: maps a bit index onto the tree layer it touches.
// An all-zero input yields IDX_W+1; callers handle index 0 themselves.
module sc_ctz_layer
    import sc_pkg::*;
#(
    parameter int IDX_W   = SC_IDX_W,
    parameter int LAYER_W = SC_LAYER_W
) (
    input  logic [IDX_W-1:0]   i_value,
    output logic [LAYER_W-1:0] o_layer
);

    logic [LAYER_W-1:0] w_ctz;

    // Scanning from the top lets the lowest set bit win.
    always_comb begin
        w_ctz = LAYER_W'(IDX_W);
        for (int k = IDX_W - 1; k >= 0; k--) begin
            if (i_value[k]) begin
                w_ctz = LAYER_W'(k);
            end
        end
    end

    assign o_layer = w_ctz + LAYER_W'(1);

endmodule

// File: rtl/sc_decode_sequencer.sv
// Step controller of the SC polar decoder: walks the bit index and issues F/G, DEC and PSU
// commands over one valid/ready channel. Optional SC_PERF_CNT_EN adds stall/handshake counters.
module sc_decode_sequencer
    import sc_pkg::*;
#(
    parameter int N_LOG   = SC_N_LOG,
    parameter int IDX_W   = SC_IDX_W,
    parameter int LAYER_W = SC_LAYER_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic [IDX_W-1:0]   o_bit_idx,
    input  logic               i_frozen_bit,
    output logic               o_cmd_valid,
    input  logic               i_cmd_ready,
    output logic [1:0]         o_cmd_op,
    output logic [LAYER_W-1:0] o_cmd_layer,
    output logic               o_cmd_frozen
`ifdef SC_PERF_CNT_EN
    ,
    output logic [31:0]        o_stall_cnt,
    output logic [31:0]        o_cmd_cnt
`endif
);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'((1 << N_LOG) - 1);
    localparam logic [LAYER_W-1:0] TOP_LAYER = LAYER_W'(N_LOG);

    sc_state_e          r_state;
    sc_state_e          w_next_state;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [IDX_W-1:0]   w_next_bit_idx;
    logic [LAYER_W-1:0] r_layer;
    logic [LAYER_W-1:0] w_next_layer;
    logic               r_first;
    logic               w_next_first;
    logic               r_frozen;
    logic               w_next_frozen;

    logic [IDX_W-1:0]   w_idx_inc;
    logic [LAYER_W-1:0] w_ctz_cur;
    logic [LAYER_W-1:0] w_ctz_next;
    logic [LAYER_W-1:0] w_start_layer;
    logic [LAYER_W-1:0] w_llr_layer;
    logic               w_cmd_valid;
    logic               w_hs;
    logic               w_accept_start;

    assign w_idx_inc = r_bit_idx + IDX_W'(1);

    sc_ctz_layer #(.IDX_W(IDX_W), .LAYER_W(LAYER_W)) u_start_layer (
        .i_value (r_bit_idx),
        .o_layer (w_ctz_cur)
    );

    sc_ctz_layer #(.IDX_W(IDX_W), .LAYER_W(LAYER_W)) u_psu_layer (
        .i_value (w_idx_inc),
        .o_layer (w_ctz_next)
    );

    // The first LLR command of a bit takes its layer from the index; later ones from r_layer.
    assign w_start_layer  = (r_bit_idx == '0) ? TOP_LAYER : w_ctz_cur;
    assign w_llr_layer    = r_first ? w_start_layer : r_layer;
    assign w_cmd_valid    = (r_state == ST_LLR) || (r_state == ST_DEC) || (r_state == ST_PSU);
    assign w_hs           = w_cmd_valid && i_cmd_ready;
    assign w_accept_start = (r_state == ST_IDLE) && i_start;

    assign o_cmd_valid = w_cmd_valid;
    assign o_busy      = w_cmd_valid;
    assign o_bit_idx   = r_bit_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_bit_idx <= '0;
            r_layer   <= '0;
            r_first   <= 1'b0;
            r_frozen  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_bit_idx <= w_next_bit_idx;
            r_layer   <= w_next_layer;
            r_first   <= w_next_first;
            r_frozen  <= w_next_frozen;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_bit_idx = r_bit_idx;
        w_next_layer   = r_layer;
        w_next_first   = r_first;
        w_next_frozen  = r_frozen;
        o_done         = 1'b0;
        o_cmd_op       = SC_F;
        o_cmd_layer    = '0;
        o_cmd_frozen   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state   = ST_LLR;
                    w_next_bit_idx = '0;
                    w_next_first   = 1'b1;
                end
            end
            ST_LLR: begin
                o_cmd_op    = (r_first && (r_bit_idx != '0)) ? SC_G : SC_F;
                o_cmd_layer = w_llr_layer;
                if (w_hs) begin
                    w_next_first = 1'b0;
                    // Layer 1 is terminal: the counter never goes below it.
                    if (w_llr_layer == LAYER_W'(1)) begin
                        w_next_state  = ST_DEC;
                        w_next_frozen = i_frozen_bit;
                    end else begin
                        w_next_layer = w_llr_layer - LAYER_W'(1);
                    end
                end
            end
            ST_DEC: begin
                o_cmd_op     = SC_DEC;
                o_cmd_frozen = r_frozen;
                if (w_hs) begin
                    if (r_bit_idx == LAST_IDX) begin
                        w_next_state   = ST_FIN;
                        w_next_bit_idx = '0;
                    end else begin
                        w_next_state = ST_PSU;
                    end
                end
            end
            ST_PSU: begin
                o_cmd_op    = SC_PSU;
                o_cmd_layer = w_ctz_next;
                if (w_hs) begin
                    w_next_state   = ST_LLR;
                    w_next_bit_idx = w_idx_inc;
                    w_next_first   = 1'b1;
                end
            end
            ST_FIN: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

`ifdef SC_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_cmd_cnt;

    // Saturating counters; they go quiet on their own once the channel idles after done.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_accept_start) begin
            r_stall_cnt <= '0;
            r_cmd_cnt   <= '0;
        end else begin
            if (w_cmd_valid && !i_cmd_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_hs && (r_cmd_cnt != '1)) begin
                r_cmd_cnt <= r_cmd_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_cmd_cnt   = r_cmd_cnt;
`endif

endmodule
